// File: rtl/lsu_mem_if.sv
// Data-bus handshake between the load/store unit (master) and the memory (slave).
interface lsu_mem_if #(
  parameter int unsigned DATA_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [DATA_W-1:0] bus_addr_o;
  logic [3:0]        bus_sel_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/lsu_mem.sv
// Memory stage: issues one registered bus access per load/store, stalls the pipeline until
// the ack, then hands the (formatted) result to write-back.
module lsu_mem #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mem_op_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  output logic [4:0]        reg_waddr_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              stall_req_o,
  output logic              excp_o,
  lsu_mem_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_we_q;
  logic [DATA_W-1:0] bus_addr_q, bus_wdata_q;
  logic [3:0]        bus_sel_q;
  logic [4:0]        rd_q;
  logic              load_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] ldata_q;

  logic              mem_req, op_legal, misalign, bad_acc, start;
  logic [3:0]        sel_n;
  logic [DATA_W-1:0] wdata_n;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ldata_fmt;

  assign mem_req = is_load_i | is_store_i;

  always_comb begin
    op_legal = 1'b0;
    case (mem_op_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  assign misalign = ((mem_op_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((mem_op_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign bad_acc  = mem_req && (!op_legal || misalign);
  assign start    = (state_q == StIdle) && mem_req && !bad_acc && !rst;

  always_comb begin
    sel_n   = 4'b1111;
    wdata_n = sdata_i;
    case (mem_op_i[1:0])
      2'b00: begin
        sel_n   = 4'b0001 << addr_i[1:0];
        wdata_n = {4{sdata_i[7:0]}};
      end
      2'b01: begin
        sel_n   = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the offset and size captured at issue, not the live ex inputs.
  always_comb begin
    byte_v = bus.bus_rdata_i[7:0];
    case (off_q)
      2'd1:    byte_v = bus.bus_rdata_i[15:8];
      2'd2:    byte_v = bus.bus_rdata_i[23:16];
      2'd3:    byte_v = bus.bus_rdata_i[31:24];
      default: byte_v = bus.bus_rdata_i[7:0];
    endcase
    half_v    = off_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    ldata_fmt = bus.bus_rdata_i;
    case (op_q)
      3'b000:  ldata_fmt = {{24{byte_v[7]}}, byte_v};
      3'b100:  ldata_fmt = {24'd0, byte_v};
      3'b001:  ldata_fmt = {{16{half_v[15]}}, half_v};
      3'b101:  ldata_fmt = {16'd0, half_v};
      default: ldata_fmt = bus.bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall_req_o = 1'b0;
    excp_o      = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    case (state_q)
      StIdle: begin
        if (bad_acc) begin
          excp_o   = 1'b1;
          reg_we_o = 1'b0;
        end else if (mem_req) begin
          stall_req_o = 1'b1;
          reg_we_o    = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        stall_req_o = 1'b1;
        reg_waddr_o = rd_q;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        if (bus.bus_ack_i) state_d = StDone;
      end
      StDone: begin
        reg_waddr_o = rd_q;
        reg_we_o    = load_q;
        reg_wdata_o = ldata_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d     = StIdle;
      stall_req_o = 1'b0;
      excp_o      = 1'b0;
      reg_waddr_o = '0;
      reg_we_o    = 1'b0;
      reg_wdata_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      rd_q        <= '0;
      load_q      <= 1'b0;
      op_q        <= '0;
      off_q       <= '0;
      ldata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= is_store_i;
        bus_addr_q  <= {addr_i[DATA_W-1:2], 2'b00};
        bus_sel_q   <= sel_n;
        bus_wdata_q <= wdata_n;
        rd_q        <= reg_waddr_i;
        load_q      <= is_load_i;
        op_q        <= mem_op_i;
        off_q       <= addr_i[1:0];
      end
      if ((state_q == StWait) && bus.bus_ack_i) begin
        bus_req_q <= 1'b0;
        ldata_q   <= ldata_fmt;
      end
    end
  end

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_sel_o   = bus_sel_q;
  assign bus.bus_wdata_o = bus_wdata_q;

endmodule
